// File: rtl/slt_seq_unit.sv
// slt_seq_unit: multi-cycle SLT/SLTU/SEQ/SNE comparator, MSB-first chunk scan.
// Optional build macro: SLT_EARLY_EXIT_EN. When it is defined, the scan ends at
// the first differing chunk. When it is undefined, every operation takes NCHUNK cycles.
// Result values do not depend on the macro; only busy/done timing changes.
module slt_seq_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] MODE_SLT  = 2'b00;
    localparam logic [1:0] MODE_SLTU = 2'b01;
    localparam logic [1:0] MODE_SEQ  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [1:0]         mode_q;
    logic [IDX_W-1:0]   idx_q;
    logic               decided_q;
    logic               lt_r_q;

    logic [CHUNK-1:0]   ca, cb;
    logic               top, last, differ, chunk_lt, fin;
    logic               lt_fin, eq_fin, flag;
    logic               accept;

    logic               busy_d, done_d, lt_d, eq_d;
    logic [WIDTH-1:0]   result_d;

    // Select the current chunk and apply the sign flip on the top chunk
    always_comb begin
        ca = '0;
        cb = '0;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            if (idx_q == IDX_W'(i)) begin
                ca = a_q[i*CHUNK +: CHUNK];
                cb = b_q[i*CHUNK +: CHUNK];
            end
        end
        top = (idx_q == IDX_W'(NCHUNK - 1));
        if ((mode_q == MODE_SLT) && top) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        differ   = (ca != cb);
        chunk_lt = (ca < cb);
        last     = (idx_q == '0);
`ifdef SLT_EARLY_EXIT_EN
        fin      = last || (!decided_q && differ);
`else
        fin      = last;
`endif
        lt_fin   = decided_q ? lt_r_q : (differ & chunk_lt);
        eq_fin   = ~(decided_q | differ);
        case (mode_q)
            MODE_SLT, MODE_SLTU: flag = lt_fin;
            MODE_SEQ:            flag = eq_fin;
            default:             flag = ~eq_fin;
        endcase
        accept = start && ((state_q == IDLE) || (state_q == DONE));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (fin)   state_d = DONE;
            DONE:    state_d = start ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values; lt/eq/result hold until the next completion
    always_comb begin
        busy_d   = (state_d == SCAN);
        done_d   = 1'b0;
        lt_d     = lt;
        eq_d     = eq;
        result_d = result;
        if ((state_q == SCAN) && fin) begin
            done_d   = 1'b1;
            lt_d     = lt_fin;
            eq_d     = eq_fin;
            result_d = WIDTH'(flag);
        end
    end

    // Registered outputs and scan datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            result    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            lt_r_q    <= 1'b0;
        end else begin
            busy   <= busy_d;
            done   <= done_d;
            lt     <= lt_d;
            eq     <= eq_d;
            result <= result_d;
            if (accept) begin
                a_q       <= a;
                b_q       <= b;
                mode_q    <= mode;
                idx_q     <= IDX_W'(NCHUNK - 1);
                decided_q <= 1'b0;
                lt_r_q    <= 1'b0;
            end else if (state_q == SCAN) begin
                if (!decided_q && differ) begin
                    decided_q <= 1'b1;
                    lt_r_q    <= chunk_lt;
                end
                if (!last) begin
                    idx_q <= idx_q - IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_slt_seq_unit.sv
// Self-checking bench for slt_seq_unit (8/2 and 16/4 instances).
module tb_slt_seq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  a, b;
    logic        busy, done, lt, eq;
    logic [7:0]  result;

    logic        start16;
    logic [1:0]  mode16;
    logic [15:0] a16, b16;
    logic        busy16, done16, lt16, eq16;
    logic [15:0] result16;

    always #5 clk = ~clk;

    slt_seq_unit #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .lt(lt), .eq(eq), .result(result)
    );

    slt_seq_unit #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .mode(mode16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .lt(lt16), .eq(eq16), .result(result16)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       lt;
        logic       eq;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       lt;
        logic       eq;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected latency: first differing chunk (MSB first) under early exit, else full scan
    function automatic int lat_of(input logic [15:0] x, input logic [15:0] y,
                                  input int w, input int c);
        int n;
        n = w / c;
`ifdef SLT_EARLY_EXIT_EN
        for (int k = n - 1; k >= 0; k--) begin
            if (((x >> (c * k)) & ((16'd1 << c) - 16'd1)) !=
                ((y >> (c * k)) & ((16'd1 << c) - 16'd1)))
                return n - k;
        end
`endif
        return n;
    endfunction

    function automatic exp_t model(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        e.eq  = (x == y);
        e.lt  = (m == 2'b00) ? ($signed(x) < $signed(y)) : (x < y);
        case (m)
            2'b00, 2'b01: e.res = {7'd0, e.lt};
            2'b10:        e.res = {7'd0, e.eq};
            default:      e.res = {7'd0, ~e.eq};
        endcase
        e.lat = lat_of({8'd0, x}, {8'd0, y}, 8, 2);
        return e;
    endfunction

    // Wait for done (bounded) and score it against the head of the queue
    task automatic wait_done(input int c0);
        int   cyc;
        bit   got;
        exp_t e;
        cyc = c0;
        got = 1'b0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("lt", 32'(lt), 32'(e.lt));
                chk("eq", 32'(eq), 32'(e.eq));
                chk("latency", 32'(cyc), 32'(e.lat));
                chk("busy_in_done", 32'(busy), 32'd0);
                prev_res = e.res;
            end
        end
    endtask

    // Drive one request at the current negedge and score its completion
    task automatic issue(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y,
                         input exp_t e);
        mode  = m;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        mode  = 2'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_after_start", 32'(done), 32'd0);
        chk("result_hold", 32'(result), 32'(prev_res));
        wait_done(0);
    endtask

    vec_t vecs[12];

    initial begin
        exp_t e;
        bit   extra;
        int   cyc;

        vecs[0]  = '{2'b00, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0};
        vecs[1]  = '{2'b01, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 8'h80, 8'h7F, 8'h01, 1'b1, 1'b0};
        vecs[3]  = '{2'b01, 8'h80, 8'h7F, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 8'h5A, 8'h5A, 8'h01, 1'b0, 1'b1};
        vecs[5]  = '{2'b11, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{2'b00, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 8'h03, 8'h05, 8'h01, 1'b1, 1'b0};
        vecs[8]  = '{2'b10, 8'h12, 8'h13, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{2'b11, 8'h12, 8'h13, 8'h01, 1'b1, 1'b0};
        vecs[10] = '{2'b00, 8'hFE, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[11] = '{2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; mode = 2'b00; a = 8'h00; b = 8'h00;
        start16 = 1'b0; mode16 = 2'b00; a16 = 16'h0; b16 = 16'h0;
        prev_res = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_lt", 32'(lt), 32'd0);
        chk("rst_eq", 32'(eq), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors, each started from IDLE
        for (int i = 0; i < 12; i++) begin
            e.res = vecs[i].res;
            e.lt  = vecs[i].lt;
            e.eq  = vecs[i].eq;
            e.lat = lat_of({8'd0, vecs[i].a}, {8'd0, vecs[i].b}, 8, 2);
            issue(vecs[i].mode, vecs[i].a, vecs[i].b, e);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
        end

        // Back-to-back SEQ then SNE, second start during the done cycle
        e = '{8'h01, 1'b0, 1'b1, 4};
        issue(2'b10, 8'h5A, 8'h5A, e);
        e = '{8'h00, 1'b0, 1'b1, 4};
        issue(2'b11, 8'h5A, 8'h5A, e);
        @(negedge clk);

        // Random operations against the model, mixed idle and back-to-back
        for (int i = 0; i < 16; i++) begin
            logic [1:0] m;
            logic [7:0] x, y;
            m = 2'($urandom_range(3));
            x = 8'($urandom);
            y = (i % 4 == 0) ? x : 8'($urandom);
            issue(m, x, y, model(m, x, y));
            if (i % 2 == 0) @(negedge clk);
        end
        @(negedge clk);

        // Start while busy is ignored
        mode = 2'b01; a = 8'h10; b = 8'h20; start = 1'b1;
        sb.push_back(model(2'b01, 8'h10, 8'h20));
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        mode = 2'b01; a = 8'h30; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2);
        chk("busy_start_result", 32'(result), 32'h01);
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra = 1'b1;
        end
        chk("no_second_done", 32'(extra), 32'd0);

        // Reset in the middle of a scan
        mode = 2'b00; a = 8'h03; b = 8'h05; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_res = 8'h00;
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        chk("midrst_no_done", 32'(extra), 32'd0);

        // 16-bit instance, CHUNK=4
        for (int j = 0; j < 2; j++) begin
            bit got;
            mode16 = (j == 0) ? 2'b00 : 2'b01;
            a16 = 16'h8000; b16 = 16'h0001; start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            a16 = 16'h0000; b16 = 16'hFFFF;
            chk("w16_busy", 32'(busy16), 32'd1);
            cyc = 0; got = 1'b0;
            while (cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (done16) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("w16_done_seen", 32'(got), 32'd1);
            chk("w16_result", 32'(result16), (j == 0) ? 32'h0001 : 32'h0000);
            chk("w16_lt", 32'(lt16), (j == 0) ? 32'd1 : 32'd0);
            chk("w16_eq", 32'(eq16), 32'd0);
            chk("w16_latency", 32'(cyc), 32'(lat_of(16'h8000, 16'h0001, 16, 4)));
            @(negedge clk);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
